// File: rtl/mem_stage.sv
// mem_stage: EX/MEM latch, data-memory access, branch resolve and MEM/WB latch.
module mem_stage #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData_3,
    input  logic [31:0] branchTarget_3,
    input  logic [4:0]  rd_3,
    input  logic        zero,
    input  logic        regWrite_3,
    input  logic        memRead_3,
    input  logic        memWrite_3,
    input  logic        memToReg_3,
    input  logic        branch_3,
    input  logic        flush_3,
    output logic [31:0] aluResult_4,
    output logic [4:0]  rd_4,
    output logic        regWrite_4,
    output logic        pcSrc_4,
    output logic [31:0] branchTarget_4,
    output logic [31:0] wrData_5,
    output logic [4:0]  rd_5,
    output logic        regWrite_5,
    output logic        memFault_4
);
    logic [31:0] r_alu_4, r_store_4, r_bt_4, r_alu_5, r_memdata_5;
    logic [4:0]  r_rd_4, r_rd_5;
    logic        r_zero_4, r_regw_4, r_memr_4, r_memw_4, r_m2r_4, r_br_4;
    logic        r_regw_5, r_m2r_5;
    logic [31:0] r_mem [DEPTH];
    logic [AW-1:0] w_addr;
    logic        w_fault;
    logic [31:0] w_load;

    assign w_addr  = r_alu_4[AW+1:2];
    assign w_fault = (r_memr_4 | r_memw_4) & ((r_alu_4[1:0] != 2'b00) | (r_alu_4[31:AW+2] != '0));
    assign w_load  = (r_memr_4 && !r_memw_4 && !w_fault) ? r_mem[w_addr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_4     <= '0;
            r_store_4   <= '0;
            r_bt_4      <= '0;
            r_rd_4      <= '0;
            r_zero_4    <= 1'b0;
            r_regw_4    <= 1'b0;
            r_memr_4    <= 1'b0;
            r_memw_4    <= 1'b0;
            r_m2r_4     <= 1'b0;
            r_br_4      <= 1'b0;
            r_alu_5     <= '0;
            r_memdata_5 <= '0;
            r_rd_5      <= '0;
            r_regw_5    <= 1'b0;
            r_m2r_5     <= 1'b0;
        end else begin
            r_alu_4     <= aluResult;
            r_store_4   <= storeData_3;
            r_bt_4      <= branchTarget_3;
            r_rd_4      <= rd_3;
            r_zero_4    <= zero;
            r_regw_4    <= regWrite_3 & ~flush_3;
            r_memr_4    <= memRead_3 & ~flush_3;
            r_memw_4    <= memWrite_3 & ~flush_3;
            r_m2r_4     <= memToReg_3 & ~flush_3;
            r_br_4      <= branch_3 & ~flush_3;
            r_alu_5     <= r_alu_4;
            r_memdata_5 <= w_load;
            r_rd_5      <= r_rd_4;
            r_regw_5    <= r_regw_4 & ~w_fault;
            r_m2r_5     <= r_m2r_4;
        end
    end

    // Contents are deliberately not reset; rst_n gates a write racing reset assertion.
    always_ff @(posedge clk) begin
        if (rst_n && r_memw_4 && !w_fault)
            r_mem[w_addr] <= r_store_4;
    end

    assign aluResult_4    = r_alu_4;
    assign rd_4           = r_rd_4;
    assign regWrite_4     = r_regw_4;
    assign pcSrc_4        = r_br_4 & r_zero_4;
    assign branchTarget_4 = r_bt_4;
    assign memFault_4     = w_fault;
    assign wrData_5       = r_m2r_5 ? r_memdata_5 : r_alu_5;
    assign rd_5           = r_rd_5;
    assign regWrite_5     = r_regw_5;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aluResult, storeData_3, branchTarget_3;
    logic [4:0]  rd_3;
    logic        zero, regWrite_3, memRead_3, memWrite_3, memToReg_3, branch_3, flush_3;
    logic [31:0] aluResult_4, branchTarget_4, wrData_5;
    logic [4:0]  rd_4, rd_5;
    logic        regWrite_4, pcSrc_4, regWrite_5, memFault_4;
    int          n_chk = 0;
    int          n_err = 0;

    mem_stage #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .aluResult(aluResult), .storeData_3(storeData_3),
        .branchTarget_3(branchTarget_3), .rd_3(rd_3), .zero(zero),
        .regWrite_3(regWrite_3), .memRead_3(memRead_3), .memWrite_3(memWrite_3),
        .memToReg_3(memToReg_3), .branch_3(branch_3), .flush_3(flush_3),
        .aluResult_4(aluResult_4), .rd_4(rd_4), .regWrite_4(regWrite_4),
        .pcSrc_4(pcSrc_4), .branchTarget_4(branchTarget_4), .wrData_5(wrData_5),
        .rd_5(rd_5), .regWrite_5(regWrite_5), .memFault_4(memFault_4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic [31:0] t,
                       input logic [4:0] r, input logic z, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic br, input logic fl);
        aluResult = a; storeData_3 = d; branchTarget_3 = t; rd_3 = r; zero = z;
        regWrite_3 = rw; memRead_3 = mr; memWrite_3 = mw; memToReg_3 = m2r;
        branch_3 = br; flush_3 = fl;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drv(a, d, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        nop();
        step();
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drv(a, 0, 0, 5'd9, 0, 1, 1, 0, 1, 0, 0);
        step();
        nop();
        step();
        chk(tag, wrData_5, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        repeat (2) step();
        chk("rst_alu4", aluResult_4, 0);
        chk("rst_regw4", regWrite_4, 0);
        chk("rst_wr5", wrData_5, 0);
        rst_n = 1'b1;

        // store then load same address back-to-back
        drv(32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("st_fault", memFault_4, 0);
        chk("st_regw4", regWrite_4, 0);
        drv(32'h10, 0, 0, 5'd5, 0, 1, 1, 0, 1, 0, 0);
        step();
        chk("ld_rd4", rd_4, 5);
        chk("ld_regw4", regWrite_4, 1);
        nop();
        step();
        chk("ld_wr5", wrData_5, 32'hDEADBEEF);
        chk("ld_rd5", rd_5, 5);
        chk("ld_regw5", regWrite_5, 1);

        // ALU pass-through timing
        drv(32'h7, 0, 0, 5'd3, 0, 1, 0, 0, 0, 0, 0);
        step();
        chk("alu_4", aluResult_4, 7);
        chk("alu_rd4", rd_4, 3);
        nop();
        step();
        chk("alu_wr5", wrData_5, 7);
        chk("alu_rd5", rd_5, 3);

        // misaligned load
        drv(32'h102, 0, 0, 5'd1, 0, 1, 1, 0, 1, 0, 0);
        step();
        chk("mis_fault", memFault_4, 1);
        nop();
        step();
        chk("mis_regw5", regWrite_5, 0);
        chk("mis_wr5", wrData_5, 0);

        // out-of-range store must not alias word 0
        store(32'h0, 32'hA5A5A5A5);
        drv(32'h400, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("oor_fault", memFault_4, 1);
        nop();
        step();
        chk("oor_nofault", memFault_4, 0);
        load_chk("oor_mem", 32'h0, 32'hA5A5A5A5);

        // read+write together acts as a store, load data zero
        drv(32'h30, 32'h77, 0, 5'd4, 0, 1, 1, 1, 1, 0, 0);
        step();
        nop();
        step();
        chk("rw_wr5", wrData_5, 0);
        load_chk("rw_mem", 32'h30, 32'h77);

        // branch taken / not taken
        drv(0, 0, 32'h40, 0, 1, 0, 0, 0, 0, 1, 0);
        step();
        chk("br_pc", pcSrc_4, 1);
        chk("br_tgt", branchTarget_4, 32'h40);
        nop();
        step();
        chk("br_once", pcSrc_4, 0);
        drv(0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk("brnt_pc", pcSrc_4, 0);

        // flushed store with branch/regWrite set
        drv(32'h10, 32'hBAD, 32'h80, 5'd2, 1, 1, 0, 1, 0, 1, 1);
        step();
        chk("fl_regw4", regWrite_4, 0);
        chk("fl_pc", pcSrc_4, 0);
        chk("fl_alu4", aluResult_4, 32'h10);
        nop();
        step();
        load_chk("fl_mem", 32'h10, 32'hDEADBEEF);

        // reset asserted while a store sits in stage 4
        store(32'h20, 32'h11);
        drv(32'h20, 32'h55, 32'h44, 5'd7, 1, 1, 0, 1, 0, 1, 0);
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_alu4", aluResult_4, 0);
        chk("mr_bt4", branchTarget_4, 0);
        chk("mr_pc", pcSrc_4, 0);
        chk("mr_regw4", regWrite_4, 0);
        step();
        chk("mr_rd4", rd_4, 0);
        chk("mr_rd5", rd_5, 0);
        chk("mr_regw5", regWrite_5, 0);
        chk("mr_fault", memFault_4, 0);
        chk("mr_wr5", wrData_5, 0);
        nop();
        step();
        rst_n = 1'b1;
        load_chk("mr_mem", 32'h20, 32'h11);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline. It latches the execute-stage results into the EX/MEM register (stage 4), performs the data-memory access, and resolves taken branches. It then latches the outcome into the MEM/WB register (stage 5). It is the source of the stage-4 and stage-5 forwarding values (`aluResult_4`, `wrData_5`) that the execute stage and forwarding unit consume.

## Interface
Parameters:
- `DEPTH`, 64: data-memory words (32-bit each); must be a power of two.
- `AW`, 6: word-address width, equal to log2(`DEPTH`).

Ports. One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `aluResult` input 32: EX-stage ALU result; used as the memory byte address.
- `storeData_3` input 32: forwarded second operand from EX, used as store data.
- `branchTarget_3` input 32: branch target computed in EX.
- `rd_3` input 5: destination register.
- `zero` input 1: ALU zero flag.
- `regWrite_3`, `memRead_3`, `memWrite_3`, `memToReg_3`, `branch_3` input 1 each: control bits from EX.
- `flush_3` input 1: squash the instruction leaving EX (bubble into stage 4).
- `aluResult_4` output 32: stage-4 ALU result (forwarding source 01).
- `rd_4` output 5, `regWrite_4` output 1: stage-4 destination and write enable (forwarding compare).
- `pcSrc_4` output 1: `branch_4 & zero_4`, taken-branch select.
- `branchTarget_4` output 32: latched branch target.
- `wrData_5` output 32: write-back data (forwarding source 10, register-file write data).
- `rd_5` output 5, `regWrite_5` output 1: write-back destination and enable.
- `memFault_4` output 1: stage-4 access is outside `DEPTH` or misaligned.

## Operation
- **EX/MEM register:** on each edge it captures all stage-3 inputs.
  - If `flush_3`=1, the control bits `regWrite`, `memRead`, `memWrite`, `branch` and `memToReg` are captured as 0. Data fields still load.
- **Word address:** `aluResult_4[AW+1:2]`.
  - `memFault_4` = (`memRead_4` | `memWrite_4`) & ((`aluResult_4[1:0]` != 0) | (`aluResult_4[31:AW+2]` != 0)).
- **Store:** if `memWrite_4` & !`memFault_4`, `mem[addr] <= storeData_4` at the edge ending the MEM cycle. Faulting stores are dropped.
- **Load:** if `memRead_4` & !`memWrite_4`, `memData_5 <= mem[addr]` at the same edge.
  - A faulting load captures 32'h0.
  - If `memRead_4` and `memWrite_4` are both set, the access is treated as a store and `memData_5 <= 0`.
- **MEM/WB register:** captures `aluResult_4`, `rd_4`, `regWrite_4`, `memToReg_4`.
  - If `memFault_4`=1, `regWrite_5` is captured as 0 (no write-back of a faulting access).
- **Write-back data (combinational):** `wrData_5` = `memToReg_5` ? `memData_5` : `aluResult_5`.
- **Branch:** `pcSrc_4` is combinational from stage-4 register bits only, never from stage-3 inputs.
- **Memory contents:** not reset. All other state is reset.
- **Stalls:** there is no stall input. Load-use stalls are handled upstream by bubbles via `flush_3`.

## Timing
- **Reset:** while `rst_n`=0, asynchronously:
  - every EX/MEM and MEM/WB field = 0, so `aluResult_4`=0, `rd_4`=0, `regWrite_4`=0, `pcSrc_4`=0, `branchTarget_4`=0, `memFault_4`=0, `wrData_5`=0, `rd_5`=0, `regWrite_5`=0;
  - no memory write occurs.
- **Reset mid-operation:** in-flight instructions in stages 4 and 5 are lost. A store whose edge coincides with reset assertion must not be written.
- **Latency:** an instruction present in EX during cycle n appears on stage-4 outputs in cycle n+1 and on stage-5 outputs in cycle n+2. A store commits at the end of cycle n+1.
- **Back-to-back store then load to the same address:** the store in MEM during cycle k and the load in MEM during cycle k+1 return the new data in cycle k+2.
- **Load immediately after a store, same cycle pair:** the memory is single-port, one access per cycle, so no read-during-write case exists.
- **Flush:** `flush_3` takes effect at the same edge and affects only the instruction entering stage 4.
- **Branch:** `pcSrc_4` is valid for exactly one cycle per taken branch. Flushing younger instructions is the fetch/decode logic's job.

## Test plan
- **Reset:** hold `rst_n`=0 mid-run with `memWrite_3`=1 → all outputs 0; after release, a load of that address shows the old contents.
- **Store/load round trip:**
  - Stimulus: store `storeData_3`=32'hDEADBEEF at `aluResult`=32'h10, then load from 32'h10 with `memToReg_3`=1, `regWrite_3`=1, `rd_3`=5.
  - Required: `wrData_5`=32'hDEADBEEF, `rd_5`=5, `regWrite_5`=1 two cycles after the load enters.
- **ALU pass-through and forwarding timing:** R-type with `aluResult`=32'h7, `rd_3`=3 → `aluResult_4`=7 and `rd_4`=3 in cycle n+1; `wrData_5`=7 in cycle n+2.
- **Fault:**
  - Load from 32'h102 (misaligned) → `memFault_4`=1, `regWrite_5`=0.
  - Store to 32'h400 (out of range, DEPTH=64) → `memFault_4`=1; memory unchanged on readback.
- **Branch:** `branch_3`=1, `zero`=1, `branchTarget_3`=32'h40 → `pcSrc_4`=1 and `branchTarget_4`=32'h40 for one cycle; the same with `zero`=0 → `pcSrc_4`=0.
- **Flush:** store with `flush_3`=1 → memory unchanged, `regWrite_4`=0, `pcSrc_4`=0.
